// File: rtl/some_sub_module_if.sv
// Sample strobe/clear/data in, windowed sum/average/fill status out.
// Latency, handshake and backpressure behaviour belong to the module that uses it.
interface some_sub_module_if #(
    parameter int WINDOW = 4
);
    localparam int W_SUM  = 4 + $clog2(WINDOW);
    localparam int W_FILL = $clog2(WINDOW) + 1;

    logic              a;
    logic              b;
    logic [3:0]        c;
    logic [W_SUM-1:0]  o_sum;
    logic [3:0]        o_avg;
    logic [W_FILL-1:0] o_fill;
    logic              o_full;
    logic              o_valid;

    modport master (
        output a, b, c,
        input  o_sum, o_avg, o_fill, o_full, o_valid
    );

    modport slave (
        input  a, b, c,
        output o_sum, o_avg, o_fill, o_full, o_valid
    );
endinterface

// File: rtl/some_sub_module.sv
// Moving sum over the last WINDOW 4-bit samples. An accepted sample shows up one cycle later.
// There is no backpressure: every strobe is taken unless clear (b) or reset wins.
module some_sub_module #(
    parameter int WINDOW = 4
) (
    input logic             i_clk,
    input logic             resetn,
    some_sub_module_if.slave bus
);
    localparam int LOG2W  = $clog2(WINDOW);
    localparam int W_SUM  = 4 + LOG2W;
    localparam int W_FILL = LOG2W + 1;

    logic [WINDOW-1:0][3:0] slot_q, slot_d;
    logic [W_SUM-1:0]       sum_q, sum_d;
    logic [W_FILL-1:0]      fill_q, fill_d;
    logic                   valid_q, valid_d;

    always_comb begin
        slot_d  = slot_q;
        sum_d   = sum_q;
        fill_d  = fill_q;
        valid_d = 1'b0;
        if (bus.b) begin
            slot_d = '0;
            sum_d  = '0;
            fill_d = '0;
        end else if (bus.a) begin
            for (int i = WINDOW - 1; i > 0; i--) begin
                slot_d[i] = slot_q[i-1];
            end
            slot_d[0] = bus.c;
            // Empty slots hold zero, so subtracting the oldest is exact while filling.
            sum_d   = sum_q + W_SUM'(bus.c) - W_SUM'(slot_q[WINDOW-1]);
            fill_d  = (fill_q == W_FILL'(WINDOW)) ? fill_q : fill_q + W_FILL'(1);
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            slot_q  <= '0;
            sum_q   <= '0;
            fill_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            sum_q   <= sum_d;
            fill_q  <= fill_d;
            valid_q <= valid_d;
        end
    end

    // The top four bits of the sum are the sum divided by WINDOW.
    assign bus.o_sum   = sum_q;
    assign bus.o_avg   = sum_q[W_SUM-1:LOG2W];
    assign bus.o_fill  = fill_q;
    assign bus.o_full  = (fill_q == W_FILL'(WINDOW));
    assign bus.o_valid = valid_q;
endmodule

// File: tb/tb_some_sub_module.sv
// Directed bench for some_sub_module with WINDOW=4.
// It compares every cycle against a sample-list model and checks the sums delivered with o_valid against a scoreboard.
module tb_some_sub_module;
    localparam int WIN = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   win_q[$];
    int   sb_q[$];
    logic exp_valid = 1'b0;

    some_sub_module_if #(.WINDOW(WIN)) bus ();

    some_sub_module #(.WINDOW(WIN)) dut (
        .i_clk (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_sum();
        int s = 0;
        foreach (win_q[i]) s += win_q[i];
        return s;
    endfunction

    task automatic check_outputs(input string tag);
        int s;
        s = model_sum();
        chk({tag, ".sum"}, 32'(bus.o_sum), s);
        chk({tag, ".avg"}, 32'(bus.o_avg), s / WIN);
        chk({tag, ".fill"}, 32'(bus.o_fill), win_q.size());
        chk({tag, ".full"}, 32'(bus.o_full), (win_q.size() == WIN) ? 1 : 0);
        chk({tag, ".valid"}, 32'(bus.o_valid), 32'(exp_valid));
        if (bus.o_valid === 1'b1) begin
            chk({tag, ".sb_nonempty"}, (sb_q.size() > 0) ? 1 : 0, 1);
            if (sb_q.size() > 0) chk({tag, ".sb_sum"}, 32'(bus.o_sum), sb_q.pop_front());
        end
    endtask

    task automatic model_reset();
        win_q.delete();
        sb_q.delete();
        exp_valid = 1'b0;
    endtask

    task automatic step(input string tag, input logic sa, input logic sb, input logic [3:0] sc);
        @(negedge clk);
        bus.a = sa;
        bus.b = sb;
        bus.c = sc;
        exp_valid = 1'b0;
        if (sb) begin
            win_q.delete();
        end else if (sa) begin
            win_q.push_front(int'(sc));
            if (win_q.size() > WIN) void'(win_q.pop_back());
            exp_valid = 1'b1;
            sb_q.push_back(model_sum());
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        bus.a = 1'b0;
        bus.b = 1'b0;
        bus.c = 4'h0;
        model_reset();

        // Strobes while reset is held must be ignored.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.a = 1'b1;
            bus.c = (i % 2 == 0) ? 4'hF : 4'h0;
            @(posedge clk);
            #1;
            check_outputs("in_reset");
        end
        @(negedge clk);
        bus.a = 1'b0;
        resetn = 1'b1;
        step("post_reset", 1'b0, 1'b0, 4'h0);
        step("post_reset", 1'b0, 1'b0, 4'h0);

        for (int i = 1; i <= 4; i++) step("fill", 1'b1, 1'b0, 4'(i));
        chk("fill_sum10", 32'(bus.o_sum), 10);
        chk("fill_avg2", 32'(bus.o_avg), 2);

        step("slide", 1'b1, 1'b0, 4'd5);
        chk("slide_sum14", 32'(bus.o_sum), 14);
        for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, 4'd9);

        for (int i = 0; i < 8; i++) step("sat", 1'b1, 1'b0, 4'hF);
        chk("sat_sum60", 32'(bus.o_sum), 60);
        chk("sat_avg15", 32'(bus.o_avg), 15);

        step("clear", 1'b0, 1'b1, 4'h0);
        for (int i = 1; i <= 4; i++) step("refill", 1'b1, 1'b0, 4'(i));
        step("clr_collide", 1'b1, 1'b1, 4'd7);
        chk("collide_sum0", 32'(bus.o_sum), 0);
        step("after_clr", 1'b1, 1'b0, 4'd7);
        chk("after_clr_avg1", 32'(bus.o_avg), 1);

        // A single sample below the window count still divides by WINDOW.
        step("clear2", 1'b0, 1'b1, 4'h0);
        step("single8", 1'b1, 1'b0, 4'd8);
        chk("single8_avg2", 32'(bus.o_avg), 2);
        step("mid", 1'b1, 1'b0, 4'd3);
        step("mid", 1'b1, 1'b0, 4'd3);
        chk("pre_rst_sum14", 32'(bus.o_sum), 14);

        // Reset asserted between clock edges must clear outputs without an edge.
        @(negedge clk);
        bus.a = 1'b0;
        @(posedge clk);
        #3;
        resetn = 1'b0;
        model_reset();
        #1;
        check_outputs("async_rst");
        @(negedge clk);
        resetn = 1'b1;
        step("after_rst", 1'b1, 1'b0, 4'd9);
        chk("after_rst_sum9", 32'(bus.o_sum), 9);

        for (int i = 0; i < 20; i++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), r);
        end
        step("drain", 1'b0, 1'b0, 4'h0);
        chk("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/some_sub_module.md
# some_sub_module

Windowed moving-sum unit for a 4-bit sample stream. It accepts one sample per strobed cycle and keeps the last WINDOW samples. It reports their running sum, floor average, fill level and a one-cycle result-valid pulse. It sits as a leaf submodule under the pipe_pal datapath, fed by a 1-bit strobe, a 1-bit clear and a 4-bit data slice.

## Interface
- WINDOW, 4, number of samples in the window; power of two, legal range 2..16.
- W_SUM, 4+$clog2(WINDOW) (derived, not overridable), width of the running sum; cannot overflow.
- W_FILL, $clog2(WINDOW)+1 (derived), width of the fill counter.
- i_clk  input  1  rising-edge clock.
- resetn  input  1  reset, asynchronous, active-low.
- a  input  1  sample strobe; c is accepted on the rising edge where a=1 and b=0 (first positional port).
- b  input  1  synchronous clear of window, sum and fill.
- c  input  4  unsigned sample data.
- o_sum  output  W_SUM  unsigned sum of samples currently held.
- o_avg  output  4  o_sum >> $clog2(WINDOW), truncating.
- o_fill  output  W_FILL  samples held, 0..WINDOW.
- o_full  output  1  o_fill == WINDOW.
- o_valid  output  1  one-cycle pulse, high the cycle after a sample is accepted.

## Operation
- Storage: WINDOW x 4-bit shift register, slot 0 newest, slot WINDOW-1 oldest. All slots are zero after reset or clear.
- Accept (a=1, b=0):
  - Data shifts in: c enters slot 0 and every slot moves one older.
  - The oldest slot value is discarded.
  - o_sum <= o_sum + c - slot[WINDOW-1]. Unfilled slots hold 0, so the formula is exact while filling.
  - o_fill increments, saturating at WINDOW.
  - o_valid <= 1.
- Idle (a=0, b=0): all state holds; o_valid <= 0.
- Clear (b=1):
  - All slots, o_sum and o_fill go to 0, and o_valid <= 0.
  - Clear takes priority over a; a sample strobed in the same cycle is dropped.
- o_avg and o_full are combinational decodes of registered o_sum and o_fill; no extra state.
- o_avg always divides by WINDOW, even when not full. Example: a single sample of 8 with WINDOW=4 gives o_avg=2.
- Arithmetic is unsigned. Sum range is 0..15*WINDOW, so W_SUM never wraps.
- Only the window contents and the two counters are stored. The sum is maintained incrementally, not recomputed by an adder tree.

## Timing
- All state updates on the rising edge of i_clk; resetn asserts asynchronously and releases synchronously to i_clk.
- Reset values: o_sum=0, o_avg=0, o_fill=0, o_full=0, o_valid=0, all slots 0.
- Latency: a sample accepted on edge N is reflected in o_sum/o_avg/o_fill/o_full and o_valid=1 from edge N+1.
- Throughput: one sample per cycle; a may stay high continuously.
- No backpressure; a sample is never refused except by b or reset.
- Clear: b high at edge N gives zeroed outputs after edge N. A strobe at edge N+1 is accepted normally.
- Reset mid-stream: all history is lost. The first sample after release gives o_fill=1 and o_sum equal to that sample.
- No output glitches beyond the combinational decode of registered values.

## Test plan
- Reset: hold resetn=0 with a=1, c=4'hF toggling -> all outputs stay 0; release -> still 0 until the first strobe.
- Fill (WINDOW=4): strobe c=1,2,3,4 on consecutive cycles -> o_sum 1,3,6,10; o_fill 1..4; o_full=1 after the 4th; o_avg=2; o_valid high four cycles.
- Slide: continue with c=5 -> o_sum=14, o_avg=3, o_fill stays 4. Then a=0 for 3 cycles -> values hold, o_valid=0.
- Saturation of data: strobe c=15 eight times -> o_sum=60, o_avg=15, no wrap; o_fill saturates at 4.
- Clear collision: with o_sum=10, drive a=1, b=1, c=7 -> next cycle o_sum=0, o_fill=0, o_valid=0. Then a=1, c=7 -> o_sum=7, o_avg=1.
- Async reset mid-stream: assert resetn low between clock edges with o_sum=14 -> outputs 0 immediately, without waiting for a clock edge. After release, strobe c=9 -> o_sum=9, o_fill=1.
